// File: rtl/systolic_pe.sv
// Systolic dot-product processing element with operand forwarding and a column drain chain.
// Optional saturating accumulate is enabled by defining SYSTOLIC_PE_SAT_EN.
module systolic_pe #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int LANES      = 1,
    parameter int PIPE_MULT  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [LANES*DATA_WIDTH-1:0]   in_left,
    input  logic                          in_left_valid,
    input  logic [LANES*DATA_WIDTH-1:0]   in_top,
    input  logic                          in_top_valid,
    input  logic                          clr,
    output logic [LANES*DATA_WIDTH-1:0]   out_right,
    output logic                          out_right_valid,
    output logic [LANES*DATA_WIDTH-1:0]   out_bottom,
    output logic                          out_bottom_valid,
    output logic [ACC_WIDTH-1:0]          acc_out,
    input  logic                          drain_load,
    input  logic                          drain_shift,
    input  logic [ACC_WIDTH-1:0]          drain_in,
    input  logic                          drain_in_valid,
    output logic [ACC_WIDTH-1:0]          drain_out,
    output logic                          drain_out_valid,
    output logic                          ovf
);

    logic signed [DATA_WIDTH-1:0]   laneL [LANES];
    logic signed [DATA_WIDTH-1:0]   laneT [LANES];
    logic signed [2*DATA_WIDTH-1:0] laneP [LANES];
    logic signed [ACC_WIDTH-1:0]    prodSum;
    logic                           fire;
    logic signed [ACC_WIDTH-1:0]    stageProd;
    logic                           stageFire;

    logic [LANES*DATA_WIDTH-1:0]    right_q, bottom_q;
    logic                           rightValid_q, bottomValid_q;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic                           ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0]           drain_q;
    logic                           drainValid_q;

    logic signed [ACC_WIDTH-1:0]    sumNext;
    logic                           ovfNow;
    logic                           restart;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign laneL[g] = in_left[g*DATA_WIDTH +: DATA_WIDTH];
        assign laneT[g] = in_top[g*DATA_WIDTH +: DATA_WIDTH];
        assign laneP[g] = laneL[g] * laneT[g];
    end

    always_comb begin
        prodSum = '0;
        for (int i = 0; i < LANES; i++) begin
            prodSum = prodSum + ACC_WIDTH'(laneP[i]);
        end
    end

    assign fire = en & in_left_valid & in_top_valid;

    // Optional product register; it only advances with en and is not flushed by clr.
    if (PIPE_MULT != 0) begin : g_pipe
        logic signed [ACC_WIDTH-1:0] prod_q;
        logic                        fire_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                prod_q <= '0;
                fire_q <= 1'b0;
            end else if (en) begin
                prod_q <= prodSum;
                fire_q <= fire;
            end
        end
        assign stageProd = prod_q;
        assign stageFire = fire_q;
    end else begin : g_nopipe
        assign stageProd = prodSum;
        assign stageFire = fire;
    end

`ifdef SYSTOLIC_PE_SAT_EN
    logic signed [ACC_WIDTH:0] sumWide;
    assign sumWide = {acc_q[ACC_WIDTH-1], acc_q} + {stageProd[ACC_WIDTH-1], stageProd};
    assign ovfNow  = sumWide[ACC_WIDTH] != sumWide[ACC_WIDTH-1];
    always_comb begin
        sumNext = sumWide[ACC_WIDTH-1:0];
        if (ovfNow) begin
            sumNext = sumWide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end
`else
    assign sumNext = acc_q + stageProd;
    assign ovfNow  = 1'b0;
`endif

    assign restart = clr | drain_load;

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (en) begin
            if (restart) begin
                acc_d = stageFire ? stageProd : '0;
                ovf_d = 1'b0;
            end else if (stageFire) begin
                acc_d = sumNext;
                ovf_d = ovf_q | ovfNow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    // Operands are forwarded whether or not they are valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            right_q       <= '0;
            bottom_q      <= '0;
            rightValid_q  <= 1'b0;
            bottomValid_q <= 1'b0;
        end else if (en) begin
            right_q       <= in_left;
            bottom_q      <= in_top;
            rightValid_q  <= in_left_valid;
            bottomValid_q <= in_top_valid;
        end
    end

    // A local load takes priority over shifting the neighbour's value in.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_q      <= '0;
            drainValid_q <= 1'b0;
        end else if (en) begin
            if (drain_load) begin
                drain_q      <= acc_q;
                drainValid_q <= 1'b1;
            end else if (drain_shift) begin
                drain_q      <= drain_in;
                drainValid_q <= drain_in_valid;
            end
        end
    end

    assign out_right        = right_q;
    assign out_right_valid  = rightValid_q;
    assign out_bottom       = bottom_q;
    assign out_bottom_valid = bottomValid_q;
    assign acc_out          = acc_q;
    assign drain_out        = drain_q;
    assign drain_out_valid  = drainValid_q;
    assign ovf              = ovf_q;

endmodule

// File: tb/tb_systolic_pe.sv
// Directed self-checking bench for systolic_pe: single-lane, four-lane, 16-bit accumulator
// and a three-cell drain chain, all driven from one linear initial block.
module tb_systolic_pe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic clr = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Single-lane pipelined cell
    logic signed [7:0]  l1 = '0, t1 = '0;
    logic               lv1 = 1'b0, tv1 = 1'b0, dl1 = 1'b0, ds1 = 1'b0, dinv1 = 1'b0;
    logic [31:0]        din1 = '0;
    logic signed [7:0]  r1, b1;
    logic               rv1, bv1, doutv1, ovf1;
    logic signed [31:0] acc1, dout1;

    systolic_pe #(.DATA_WIDTH(8), .ACC_WIDTH(32), .LANES(1), .PIPE_MULT(1)) u1 (
        .clk(clk), .rst(rst), .en(en),
        .in_left(l1), .in_left_valid(lv1), .in_top(t1), .in_top_valid(tv1), .clr(clr),
        .out_right(r1), .out_right_valid(rv1), .out_bottom(b1), .out_bottom_valid(bv1),
        .acc_out(acc1), .drain_load(dl1), .drain_shift(ds1), .drain_in(din1),
        .drain_in_valid(dinv1), .drain_out(dout1), .drain_out_valid(doutv1), .ovf(ovf1)
    );

    // Four-lane unpipelined cell
    logic [31:0]        l4 = '0, t4 = '0, r4, b4, dout4;
    logic               v4 = 1'b0, rv4, bv4, doutv4, ovf4;
    logic signed [31:0] acc4;

    systolic_pe #(.DATA_WIDTH(8), .ACC_WIDTH(32), .LANES(4), .PIPE_MULT(0)) u4 (
        .clk(clk), .rst(rst), .en(en),
        .in_left(l4), .in_left_valid(v4), .in_top(t4), .in_top_valid(v4), .clr(clr),
        .out_right(r4), .out_right_valid(rv4), .out_bottom(b4), .out_bottom_valid(bv4),
        .acc_out(acc4), .drain_load(1'b0), .drain_shift(1'b0), .drain_in(32'd0),
        .drain_in_valid(1'b0), .drain_out(dout4), .drain_out_valid(doutv4), .ovf(ovf4)
    );

    // 16-bit accumulator cell for wrap/saturation
    logic [7:0]         l16 = '0, t16 = '0, r16, b16;
    logic               v16 = 1'b0, rv16, bv16, doutv16, ovf16;
    logic signed [15:0] acc16;
    logic [15:0]        dout16;

    systolic_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .LANES(1), .PIPE_MULT(1)) u16 (
        .clk(clk), .rst(rst), .en(en),
        .in_left(l16), .in_left_valid(v16), .in_top(t16), .in_top_valid(v16), .clr(clr),
        .out_right(r16), .out_right_valid(rv16), .out_bottom(b16), .out_bottom_valid(bv16),
        .acc_out(acc16), .drain_load(1'b0), .drain_shift(1'b0), .drain_in(16'd0),
        .drain_in_valid(1'b0), .drain_out(dout16), .drain_out_valid(doutv16), .ovf(ovf16)
    );

    // Three-cell column; cdi[k+1] is the drain output of cell k, cdi[3] is the bottom
    logic [7:0]  cl [3];
    logic [7:0]  ct [3];
    logic        vC = 1'b0, dlC = 1'b0, dsC = 1'b0;
    logic [31:0] cdi [4];
    logic        cdiv [4];
    logic [7:0]  cr [3];
    logic [7:0]  cb [3];
    logic        crv [3];
    logic        cbv [3];
    logic        covf [3];
    logic [31:0] cacc [3];

    assign cdi[0]  = '0;
    assign cdiv[0] = 1'b0;

    for (genvar k = 0; k < 3; k++) begin : g_chain
        systolic_pe #(.DATA_WIDTH(8), .ACC_WIDTH(32), .LANES(1), .PIPE_MULT(1)) uc (
            .clk(clk), .rst(rst), .en(en),
            .in_left(cl[k]), .in_left_valid(vC), .in_top(ct[k]), .in_top_valid(vC), .clr(clr),
            .out_right(cr[k]), .out_right_valid(crv[k]), .out_bottom(cb[k]),
            .out_bottom_valid(cbv[k]), .acc_out(cacc[k]), .drain_load(dlC), .drain_shift(dsC),
            .drain_in(cdi[k]), .drain_in_valid(cdiv[k]), .drain_out(cdi[k+1]),
            .drain_out_valid(cdiv[k+1]), .ovf(covf[k])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            cl[k] = '0;
            ct[k] = '0;
        end

        // Reset with en high and controls asserted
        rst = 1'b1; en = 1'b1; clr = 1'b1; dl1 = 1'b1;
        tick();
        checkOutput("rst_acc",    acc1,   0);
        checkOutput("rst_drain",  dout1,  0);
        checkOutput("rst_dvalid", doutv1, 0);
        checkOutput("rst_right",  r1,     0);
        checkOutput("rst_rvalid", rv1,    0);
        checkOutput("rst_ovf",    ovf1,   0);
        rst = 1'b0; dl1 = 1'b0;
        tick();
        clr = 1'b0;

        // Three pairs on consecutive cycles, pipelined product
        l1 = 3;  t1 = 4;  lv1 = 1'b1; tv1 = 1'b1;
        tick();
        checkOutput("fwd_right",   r1,   3);
        checkOutput("fwd_bottom",  b1,   4);
        checkOutput("fwd_rvalid",  rv1,  1);
        checkOutput("fwd_bvalid",  bv1,  1);
        checkOutput("acc_latency", acc1, 0);
        l1 = -2; t1 = 5;
        tick();
        checkOutput("acc_pair1", acc1, 12);
        l1 = 7;  t1 = -1;
        tick();
        checkOutput("acc_pair2", acc1, 2);
        lv1 = 1'b0; tv1 = 1'b0;
        tick();
        checkOutput("acc_pair3", acc1, -5);
        checkOutput("fwd_bottom_neg", b1, -1);
        tick();
        checkOutput("acc_hold",   acc1, -5);
        checkOutput("rvalid_low", rv1,  0);

        // Freeze with en low while operands and controls are active
        en = 1'b0; clr = 1'b1; dl1 = 1'b1; ds1 = 1'b1;
        l1 = 10; t1 = 10; lv1 = 1'b1; tv1 = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("frz_acc",    acc1,   -5);
        checkOutput("frz_right",  r1,     7);
        checkOutput("frz_bottom", b1,     -1);
        checkOutput("frz_rvalid", rv1,    0);
        checkOutput("frz_dvalid", doutv1, 0);
        checkOutput("frz_drain",  dout1,  0);
        en = 1'b1; clr = 1'b0; dl1 = 1'b0; ds1 = 1'b0; lv1 = 1'b0; tv1 = 1'b0;
        tick();
        checkOutput("frz_stage_kept", acc1, -5);

        // Build acc=50 then drain_load while a product of 6 is staged
        clr = 1'b1;
        tick();
        clr = 1'b0;
        l1 = 5; t1 = 10; lv1 = 1'b1; tv1 = 1'b1;
        tick();
        l1 = 2; t1 = 3;
        tick();
        checkOutput("acc_50", acc1, 50);
        lv1 = 1'b0; tv1 = 1'b0; dl1 = 1'b1;
        tick();
        checkOutput("load_drain",  dout1,  50);
        checkOutput("load_dvalid", doutv1, 1);
        checkOutput("load_acc",    acc1,   6);
        dl1 = 1'b0; ds1 = 1'b1; din1 = 123; dinv1 = 1'b1;
        tick();
        checkOutput("shift_drain",  dout1,  123);
        checkOutput("shift_dvalid", doutv1, 1);
        checkOutput("shift_acc",    acc1,   6);
        dl1 = 1'b1; din1 = 999; dinv1 = 1'b0;
        tick();
        checkOutput("loadwins_drain",  dout1,  6);
        checkOutput("loadwins_dvalid", doutv1, 1);
        checkOutput("loadwins_acc",    acc1,   0);
        dl1 = 1'b0; ds1 = 1'b0;
        tick();
        checkOutput("drain_hold", dout1, 6);

        // Reset mid-tile with en low discards the staged product
        l1 = 4; t1 = 4; lv1 = 1'b1; tv1 = 1'b1;
        tick();
        en = 1'b0; rst = 1'b1;
        tick();
        checkOutput("rstmid_acc",    acc1,   0);
        checkOutput("rstmid_right",  r1,     0);
        checkOutput("rstmid_rvalid", rv1,    0);
        checkOutput("rstmid_bvalid", bv1,    0);
        checkOutput("rstmid_drain",  dout1,  0);
        checkOutput("rstmid_dvalid", doutv1, 0);
        rst = 1'b0; en = 1'b1; lv1 = 1'b0; tv1 = 1'b0;
        tick();
        checkOutput("rstmid_stage_gone", acc1, 0);
        l1 = 2; t1 = 3; lv1 = 1'b1; tv1 = 1'b1;
        tick();
        lv1 = 1'b0; tv1 = 1'b0;
        tick();
        checkOutput("rstmid_from_zero", acc1, 6);

        // Four lanes, unpipelined: one-cycle accumulate
        clr = 1'b1;
        tick();
        clr = 1'b0;
        l4 = 32'h01020304; t4 = 32'hFFFF_FFFF; v4 = 1'b1;
        tick();
        checkOutput("lane4_acc",    acc4, -10);
        checkOutput("lane4_right",  r4,   32'h01020304);
        checkOutput("lane4_bottom", b4,   32'hFFFF_FFFF);
        t4 = 32'h0100_0000;
        tick();
        checkOutput("lane4_pairing", acc4, -9);
        v4 = 1'b0;
        tick();
        checkOutput("lane4_hold", acc4, -9);

        // 16-bit accumulator: three 127*127 products
        clr = 1'b1;
        tick();
        clr = 1'b0;
        l16 = 8'd127; t16 = 8'd127; v16 = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("acc16_two", acc16, 32258);
        checkOutput("ovf16_two", ovf16, 0);
        v16 = 1'b0;
        tick();
`ifdef SYSTOLIC_PE_SAT_EN
        checkOutput("acc16_sat", acc16, 32767);
        checkOutput("ovf16_set", ovf16, 1);
        tick();
        checkOutput("ovf16_sticky", ovf16, 1);
`else
        checkOutput("acc16_wrap", acc16, -17149);
        checkOutput("ovf16_zero", ovf16, 0);
`endif
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checkOutput("acc16_clr", acc16, 0);
        checkOutput("ovf16_clr", ovf16, 0);

        // Three-cell column: load 10/20/30 then shift them out of the bottom
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cl[k] = 8'((k + 1) * 10);
            ct[k] = 8'd1;
        end
        vC = 1'b1;
        tick();
        vC = 1'b0;
        tick();
        checkOutput("chain_acc0", cacc[0], 10);
        dlC = 1'b1;
        tick();
        dlC = 1'b0;
        checkOutput("chain_bot_load",  cdi[3],  30);
        checkOutput("chain_bot_valid", cdiv[3], 1);
        dsC = 1'b1;
        tick();
        checkOutput("chain_shift1", cdi[3], 20);
        tick();
        checkOutput("chain_shift2", cdi[3], 10);
        tick();
        checkOutput("chain_shift3",  cdi[3],  0);
        checkOutput("chain_empty",   cdiv[3], 0);
        dsC = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_pe.md
SYSTOLIC_PE -- requirements
Module: systolic_pe

Interface
REQ-001 Parameter DATA_WIDTH, default 8: signed operand width per lane.
REQ-002 Parameter ACC_WIDTH, default 32: signed accumulator width; SHALL be at least 2*DATA_WIDTH+clog2(LANES).
REQ-003 Parameter LANES, default 1: operand pairs multiplied per cycle; their products are summed (dot-product PE).
REQ-004 Parameter PIPE_MULT, default 1: 1 = registered product stage; 0 = product feeds accumulator directly.
REQ-005 clk  in  1  clock; all state on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 en  in  1  global advance; 0 = every register holds.
REQ-008 in_left  in  LANES*DATA_WIDTH  row operands, lane 0 in LSBs; in_left_valid  in  1.
REQ-009 in_top  in  LANES*DATA_WIDTH  column operands; in_top_valid  in  1.
REQ-010 clr  in  1  start new tile: accumulator restarts.
REQ-011 out_right / out_right_valid  out  LANES*DATA_WIDTH / 1  registered forward of in_left / in_left_valid.
REQ-012 out_bottom / out_bottom_valid  out  LANES*DATA_WIDTH / 1  registered forward of in_top / in_top_valid.
REQ-013 acc_out  out  ACC_WIDTH  current accumulator.
REQ-014 drain_load  in  1  move accumulator into drain register.
REQ-015 drain_shift  in  1  shift the column drain chain one step.
REQ-016 drain_in / drain_in_valid  in  ACC_WIDTH / 1  drain chain input from the cell above.
REQ-017 drain_out / drain_out_valid  out  ACC_WIDTH / 1  drain register contents and occupied flag.
REQ-018 ovf  out  1  sticky saturation flag.

Function
REQ-019 With en=1: out_right, out_right_valid, out_bottom, out_bottom_valid SHALL take their inputs every cycle (1-cycle latency, data forwarded regardless of valid).
REQ-020 Product fire = en & in_left_valid & in_top_valid; product = signed sum over lanes of in_left[i]*in_top[i], sign-extended to ACC_WIDTH.
REQ-021 PIPE_MULT=1: product and its fire flag registered; accumulator updates the following cycle; acc_out reflects the operands 2 cycles after presentation. PIPE_MULT=0: 1 cycle.
REQ-022 Accumulate: acc <= acc + product when the (staged) fire flag is set; otherwise acc holds.
REQ-023 clr with en=1: acc <= product if fire-stage set, else 0; ovf cleared; clr does not flush the PIPE_MULT stage.
REQ-024 drain_load with en=1: drain register <= acc value before this cycle's update, drain_out_valid <= 1, and acc restarts exactly as for clr.
REQ-025 drain_shift with en=1 and no drain_load: drain register <= drain_in, drain_out_valid <= drain_in_valid.
REQ-026 drain_load and drain_shift same cycle: drain_load wins for this cell.
REQ-027 Neither drain_load nor drain_shift: drain register and drain_out_valid hold.
REQ-028 Default arithmetic wraps modulo 2^ACC_WIDTH.
REQ-029 en=0: no state changes, including staged product, ovf, drain chain.

Reset
REQ-030 rst=1 at a clock edge SHALL zero acc, staged product and fire flag, out_right, out_bottom, all valid outputs, drain register and ovf, overriding en, clr and drain controls.
REQ-031 Reset mid-tile discards the partial sum and staged product; the first fire after deassertion accumulates from 0.

Configuration
REQ-032 Macro SYSTOLIC_PE_SAT_EN defined: an accumulate that leaves the signed ACC_WIDTH range clamps to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1) and sets ovf, held until clr, drain_load or rst.
REQ-033 SYSTOLIC_PE_SAT_EN undefined: wrap per REQ-028; ovf constant 0.

Verification
REQ-034 LANES=1, PIPE_MULT=1: clr, then valid pairs (3,4),(-2,5),(7,-1) on consecutive cycles -> acc_out 12,2,-5 on cycles 2,3,4 after the first pair.
REQ-035 LANES=4: in_left={1,2,3,4}, in_top={-1,-1,-1,-1}, one fire -> acc_out=-10; out_right/out_bottom equal inputs 1 cycle later.
REQ-036 acc=50, drain_load with a product of 6 firing in the same cycle -> drain_out=50, drain_out_valid=1, acc_out=6; three cells chained, three drain_shift cycles -> values exit the bottom in order.
REQ-037 ACC_WIDTH=16, SAT_EN defined, accumulate 127*127 three times -> acc_out=32767, ovf=1; clr -> ovf=0. Undefined -> acc_out=-17149, ovf=0.
REQ-038 en=0 for 5 cycles with valid operands -> all outputs frozen; rst asserted mid-tile with en=0 -> all outputs 0 next cycle.
